// File: rtl/pc_sequencer.sv
// pc_sequencer: program-flow unit at the head of the IF stage.
//   Holds the registered program counter, produces pc+1, selects the next PC
//   (return / sequential / conditional branch / register jump / immediate
//   jump) and keeps a circular return-address stack (RAS) for call/return.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall                 hold pc, RAS, count and underflow flag this cycle
//   BS[1:0]               branch select: 00 seq, 01 cond, 10 reg jump, 11 imm jump
//   PS[1:0], Z            branch condition: PS[0] take on Z, PS[1] take on !Z
//   BrA, RAA, JMP         conditional / register / immediate targets
//   call, ret             push return address (only with BS[1]=1) / pop to pc
//   pc, pc_1              current PC (registered) and pc+1 (combinational)
//   taken                 next PC is a redirect rather than pc_1
//   ras_empty, ras_full   RAS occupancy flags
//   ras_underflow         sticky: ret seen with an empty RAS
module pc_sequencer #(
  parameter int unsigned     PC_W      = 16,
  parameter int unsigned     RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [1:0]      BS,
  input  logic [1:0]      PS,
  input  logic            Z,
  input  logic [PC_W-1:0] BrA,
  input  logic [PC_W-1:0] RAA,
  input  logic [PC_W-1:0] JMP,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_1,
  output logic            taken,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow
);

  localparam int unsigned    PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned    CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;   // index of the most recent entry
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uflow_q, uflow_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];

  logic [PC_W-1:0]  pc_1_s;
  logic [PC_W-1:0]  next_pc_s;
  logic [PTR_W-1:0] top_inc_s;
  logic             taken_s, push_s, pop_s, uflow_set_s, cond_s, ras_we_s;

  assign pc_1_s    = pc_q + PC_W'(1);
  assign top_inc_s = top_q + PTR_W'(1);   // wraps naturally: depth is a power of 2
  assign cond_s    = (PS[0] & Z) | (PS[1] & ~Z);

  always_comb begin
    next_pc_s   = pc_1_s;
    taken_s     = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    uflow_set_s = 1'b0;
    pc_d        = pc_q;
    top_d       = top_q;
    cnt_d       = cnt_q;
    uflow_d     = uflow_q;

    // ret outranks every BS source; it also suppresses a simultaneous call.
    if (ret) begin
      if (cnt_q != '0) begin
        next_pc_s = ras_q[top_q];
        taken_s   = 1'b1;
        pop_s     = 1'b1;
      end else begin
        uflow_set_s = 1'b1;
      end
    end else begin
      unique case (BS)
        2'b00: next_pc_s = pc_1_s;
        2'b01: begin
          if (cond_s) begin
            next_pc_s = BrA;
            taken_s   = 1'b1;
          end
        end
        2'b10: begin
          next_pc_s = RAA;
          taken_s   = 1'b1;
        end
        default: begin
          next_pc_s = JMP;
          taken_s   = 1'b1;
        end
      endcase
      push_s = call & BS[1];
    end

    if (!stall) begin
      pc_d = next_pc_s;
      if (push_s) begin
        // When full the write at top+1 lands on the oldest entry.
        top_d = top_inc_s;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      end
      if (pop_s) begin
        top_d = top_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (uflow_set_s) uflow_d = 1'b1;
    end
  end

  assign ras_we_s = push_s & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      top_q   <= '0;
      cnt_q   <= '0;
      uflow_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      uflow_q <= uflow_d;
    end
  end

  // Entry storage needs no reset: an empty count makes its contents unreachable.
  always_ff @(posedge clk) begin
    if (ras_we_s) ras_q[top_inc_s] <= pc_1_s;
  end

  assign pc            = pc_q;
  assign pc_1          = pc_1_s;
  assign taken         = taken_s;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CNT_MAX);
  assign ras_underflow = uflow_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: reset checks, a vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_pc_sequencer;

  logic        clk, rst_n, stall, Z, call, ret;
  logic [1:0]  BS, PS;
  logic [15:0] BrA, RAA, JMP;
  logic [15:0] pc, pc_1, pc_w, pc_1_w;
  logic        taken, ras_empty, ras_full, ras_underflow;
  logic        taken_w, empty_w, full_w, uflow_w;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .BS(BS), .PS(PS), .Z(Z),
    .BrA(BrA), .RAA(RAA), .JMP(JMP), .call(call), .ret(ret),
    .pc(pc), .pc_1(pc_1), .taken(taken), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  pc_sequencer #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .BS(BS), .PS(PS), .Z(Z),
    .BrA(BrA), .RAA(RAA), .JMP(JMP), .call(call), .ret(ret),
    .pc(pc_w), .pc_1(pc_1_w), .taken(taken_w), .ras_empty(empty_w),
    .ras_full(full_w), .ras_underflow(uflow_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  bs;
    logic [1:0]  ps;
    logic        z;
    logic [15:0] tgt;
    logic        c;
    logic        r;
    logic        exp_taken;
    logic [15:0] exp_pc;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] bs, input logic [1:0] ps, input logic z,
                       input logic [15:0] tgt, input logic c, input logic r,
                       input logic s);
    BS = bs; PS = ps; Z = z; BrA = tgt; RAA = tgt; JMP = tgt;
    call = c; ret = r; stall = s;
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // jump to a PC without touching the RAS
  task automatic goto_pc(input logic [15:0] a);
    drive(2'b11, 2'b00, 1'b0, a, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // reference model state
  logic [15:0] m_pc;
  logic [15:0] m_stk[$];
  logic        m_uf;

  initial begin
    logic [15:0] rets[4];

    // vector table: starts from pc=0 with an empty RAS
    vecs[0]  = '{2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b1};
    vecs[1]  = '{2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002, 1'b1};
    vecs[2]  = '{2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1};
    vecs[3]  = '{2'b01, 2'b01, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b1};
    vecs[4]  = '{2'b01, 2'b01, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0041, 1'b1};
    vecs[5]  = '{2'b01, 2'b10, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b1};
    vecs[6]  = '{2'b01, 2'b11, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b1};
    vecs[7]  = '{2'b01, 2'b11, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0040, 1'b1};
    vecs[8]  = '{2'b01, 2'b00, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0041, 1'b1};
    vecs[9]  = '{2'b01, 2'b10, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0042, 1'b1};
    vecs[10] = '{2'b11, 2'b00, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b1};
    vecs[11] = '{2'b11, 2'b00, 1'b0, 16'h0100, 1'b1, 1'b0, 1'b1, 16'h0100, 1'b0};
    vecs[12] = '{2'b00, 2'b00, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b0};
    vecs[13] = '{2'b10, 2'b00, 1'b0, 16'h0500, 1'b0, 1'b0, 1'b1, 16'h0500, 1'b0};
    vecs[14] = '{2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0011, 1'b1};
    vecs[15] = '{2'b01, 2'b11, 1'b0, 16'h0070, 1'b1, 1'b0, 1'b1, 16'h0070, 1'b1};

    // ---- reset state ----
    do_reset();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc_1", pc_1, 16'h0001);
    chk("rst_taken", taken, 1'b0);
    chk("rst_empty", ras_empty, 1'b1);
    chk("rst_full", ras_full, 1'b0);
    chk("rst_uflow", ras_underflow, 1'b0);
    chk("rstw_pc", pc_w, 16'hFFFF);
    chk("rstw_pc_1", pc_1_w, 16'h0000);

    // ---- table ----
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].bs, vecs[i].ps, vecs[i].z, vecs[i].tgt, vecs[i].c, vecs[i].r, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_taken", i), taken, vecs[i].exp_taken);
      tick();
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_pc_1", i), pc_1, vecs[i].exp_pc + 16'd1);
      chk($sformatf("vec%0d_empty", i), ras_empty, vecs[i].exp_empty);
      if (i == 0) chk("wrap_pc", pc_w, 16'h0000);
    end

    // ---- RAS overflow and underflow ----
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      goto_pc(16'(k));
      drive(2'b11, 2'b00, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk("ovf_pc", pc, 16'h0200);
    chk("ovf_full", ras_full, 1'b1);
    chk("ovf_empty", ras_empty, 1'b0);
    rets = '{16'h0006, 16'h0005, 16'h0004, 16'h0003};
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("ovf_ret%0d_taken", k), taken, 1'b1);
      tick();
      chk($sformatf("ovf_ret%0d_pc", k), pc, rets[k]);
    end
    chk("ovf_drained", ras_empty, 1'b1);
    drive(2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("udf_taken", taken, 1'b0);
    tick();
    chk("udf_pc", pc, 16'h0004);
    chk("udf_flag", ras_underflow, 1'b1);
    idle();
    tick();
    chk("udf_sticky", ras_underflow, 1'b1);
    chk("udf_next_pc", pc, 16'h0005);

    // ---- stall ----
    do_reset();
    drive(2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    tick();
    chk("stall_ret_uflow", ras_underflow, 1'b0);
    chk("stall_ret_pc", pc, 16'h0000);
    goto_pc(16'h0020);
    for (int k = 0; k < 2; k++) begin
      drive(2'b11, 2'b00, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      chk("stall_taken", taken, 1'b1);
      tick();
      chk("stall_pc", pc, 16'h0020);
      chk("stall_empty", ras_empty, 1'b1);
    end
    drive(2'b11, 2'b00, 1'b0, 16'h0300, 1'b1, 1'b0, 1'b0);
    tick();
    chk("unstall_pc", pc, 16'h0300);
    chk("unstall_empty", ras_empty, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk("unstall_ret_pc", pc, 16'h0021);
    chk("unstall_ret_empty", ras_empty, 1'b1);

    // ---- call+ret together, then async reset ----
    do_reset();
    goto_pc(16'h0030);
    drive(2'b11, 2'b00, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0);
    tick();
    goto_pc(16'h004F);
    drive(2'b11, 2'b00, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0);
    tick();
    drive(2'b11, 2'b00, 1'b0, 16'h0300, 1'b1, 1'b1, 1'b0);
    tick();
    chk("cr_pc", pc, 16'h0050);
    chk("cr_empty", ras_empty, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk("cr_ret_pc", pc, 16'h0031);
    chk("cr_ret_empty", ras_empty, 1'b1);
    drive(2'b11, 2'b00, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0);
    tick();
    chk("ar_pre_empty", ras_empty, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("ar_pc", pc, 16'h0000);
    chk("ar_empty", ras_empty, 1'b1);
    chk("ar_w_pc", pc_w, 16'hFFFF);
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_after_pc", pc, 16'h0001);

    // ---- randomized run against the model ----
    do_reset();
    m_pc = 16'h0000;
    m_stk.delete();
    m_uf = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      logic [1:0]  r_bs, r_ps;
      logic        r_z, r_c, r_r, r_s, e_tk, do_push, do_pop, do_uf;
      logic [15:0] r_bra, r_raa, r_jmp, e_nx;
      r_bs  = 2'($urandom_range(0, 3));
      r_ps  = 2'($urandom_range(0, 3));
      r_z   = 1'($urandom_range(0, 1));
      r_c   = ($urandom_range(0, 2) == 0);
      r_r   = ($urandom_range(0, 4) == 0);
      r_s   = ($urandom_range(0, 7) == 0);
      r_bra = 16'($urandom);
      r_raa = 16'($urandom);
      r_jmp = 16'($urandom);
      BS = r_bs; PS = r_ps; Z = r_z; call = r_c; ret = r_r; stall = r_s;
      BrA = r_bra; RAA = r_raa; JMP = r_jmp;

      e_nx = m_pc + 16'd1; e_tk = 1'b0;
      do_push = 1'b0; do_pop = 1'b0; do_uf = 1'b0;
      if (r_r) begin
        if (m_stk.size() > 0) begin
          e_nx = m_stk[$]; e_tk = 1'b1; do_pop = 1'b1;
        end else begin
          do_uf = 1'b1;
        end
      end else begin
        if (r_bs == 2'd1 && ((r_ps[0] && r_z) || (r_ps[1] && !r_z))) begin
          e_nx = r_bra; e_tk = 1'b1;
        end else if (r_bs == 2'd2) begin
          e_nx = r_raa; e_tk = 1'b1;
        end else if (r_bs == 2'd3) begin
          e_nx = r_jmp; e_tk = 1'b1;
        end
        do_push = r_c && (r_bs >= 2'd2);
      end

      @(negedge clk);
      chk("rnd_taken", taken, e_tk);
      tick();
      if (!r_s) begin
        if (do_pop) void'(m_stk.pop_back());
        if (do_push) begin
          m_stk.push_back(m_pc + 16'd1);
          if (m_stk.size() > 4) void'(m_stk.pop_front());
        end
        if (do_uf) m_uf = 1'b1;
        m_pc = e_nx;
      end
      chk("rnd_pc", pc, m_pc);
      chk("rnd_pc_1", pc_1, m_pc + 16'd1);
      chk("rnd_empty", ras_empty, m_stk.size() == 0);
      chk("rnd_full", ras_full, m_stk.size() == 4);
      chk("rnd_uflow", ras_underflow, m_uf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
